// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM stage: state encoding, redirect sources, default widths.
package mips_mem_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_REG_A_W     = 5;
    localparam int DEF_TIMEOUT_CYC = 16;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    typedef enum logic [2:0] {
        RS_NONE,
        RS_BR,
        RS_JMP,
        RS_CALL,
        RS_RET
    } redir_src_e;

    // RET outranks CALL outranks JMP outranks BR
    function automatic redir_src_e redir_src(input logic br, input logic jmp,
                                             input logic call, input logic ret);
        redir_src_e src;
        src = RS_NONE;
        if (ret)       src = RS_RET;
        else if (call) src = RS_CALL;
        else if (jmp)  src = RS_JMP;
        else if (br)   src = RS_BR;
        return src;
    endfunction

endpackage

// File: rtl/stage4_mem_access_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
interface stage4_mem_access_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ack);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ack);
endinterface

// File: rtl/stage4_mem_if.sv
// MEM-stage access controller: IDLE/ACCESS FSM, req/ack handshake and stall.
// Optional access timeout with sticky error when MEM_TIMEOUT_EN is defined.
//  state  | meaning
//  IDLE   | no access pending; new access latched and launched
//  ACCESS | mem_req held with latched addr/we/wdata until ack (or timeout)
module stage4_mem_if
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                acc,
    input  logic                acc_we,
    input  logic [ADDR_W-1:0]   acc_addr,
    input  logic [DATA_W-1:0]   acc_wdata,
    stage4_mem_access_if.master mem,
    output logic                stall,
    output logic                done,
    output logic                abort,
    output logic                mem_err
);

    logic [0:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             mem_err_q, mem_err_d;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        stall   = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    stall   = 1'b1;
                    state_d = ST_ACCESS;
                    we_d    = acc_we;
                    addr_d  = acc_addr;
                    wdata_d = acc_wdata;
                end
            end
            default: begin
                if (mem.mem_ack) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
`ifdef MEM_TIMEOUT_EN
                // abort releases stall so the aborted op retires as a bubble
                else if (tmo_cnt_q == '0) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
                else begin
                    stall = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // down-counter preloaded in IDLE; terminal count 0 marks the last ACCESS cycle
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_IDLE)
            tmo_cnt_d = CNT_W'(TIMEOUT_CYC - 1);
        else if (tmo_cnt_q != '0)
            tmo_cnt_d = tmo_cnt_q - CNT_W'(1);
        mem_err_d = mem_err_q | abort;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign mem.mem_req   = (state_q == ST_ACCESS);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: rtl/stage4_mem_access.sv
// MIPS MEM stage: loads/stores/CALL/RET over req/ack, MEM/WB registers, PC redirect.
// MEM_TIMEOUT_EN enables the access timeout inside stage4_mem_if.
module stage4_mem_access
    import mips_mem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int REG_A_W     = DEF_REG_A_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   Result_in,
    input  logic [DATA_W-1:0]   data1_in,
    input  logic [15:0]         imm_in,
    input  logic [ADDR_W-1:0]   SP_Data_in,
    input  logic                Memory_Read_in,
    input  logic                Memory_Write_in,
    input  logic                Reg_Write_En_in,
    input  logic                WB_Mux_sel_in,
    input  logic [REG_A_W-1:0]  Addr_Write_Reg_in,
    input  logic                BR_Ex_in,
    input  logic                JMP_flag_in,
    input  logic                CALL_flag_in,
    input  logic                RET_flag_in,
    output logic                stall,
    stage4_mem_access_if.master mem,
    output logic [DATA_W-1:0]   wb_data,
    output logic [REG_A_W-1:0]  wb_addr,
    output logic                wb_we,
    output logic                pc_redirect,
    output logic [DATA_W-1:0]   pc_target,
    output logic                mem_err
);

    logic              acc, acc_we, done, abort, capture;
    logic [ADDR_W-1:0] acc_addr;
    redir_src_e        src;

    logic [DATA_W-1:0]  wb_data_q, wb_data_d;
    logic [REG_A_W-1:0] wb_addr_q, wb_addr_d;
    logic               wb_we_q, wb_we_d;
    logic               pc_redirect_q, pc_redirect_d;
    logic [DATA_W-1:0]  pc_target_q, pc_target_d;

    assign acc      = Memory_Read_in | Memory_Write_in | CALL_flag_in | RET_flag_in;
    assign acc_we   = Memory_Write_in | CALL_flag_in;
    assign acc_addr = (CALL_flag_in | RET_flag_in) ? SP_Data_in : Result_in[ADDR_W-1:0];
    assign src      = redir_src(BR_Ex_in, JMP_flag_in, CALL_flag_in, RET_flag_in);

    stage4_mem_if #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_mem_if (
        .clk       (clk),
        .reset     (reset),
        .acc       (acc),
        .acc_we    (acc_we),
        .acc_addr  (acc_addr),
        .acc_wdata (data1_in),
        .mem       (mem),
        .stall     (stall),
        .done      (done),
        .abort     (abort),
        .mem_err   (mem_err)
    );

    // Stage3 inputs are held while stalled, so they are still valid on the ack cycle
    assign capture = !stall && !abort;

    always_comb begin
        wb_data_d     = wb_data_q;
        wb_addr_d     = wb_addr_q;
        wb_we_d       = 1'b0;
        pc_redirect_d = 1'b0;
        pc_target_d   = pc_target_q;
        if (capture) begin
            wb_data_d     = (WB_Mux_sel_in && done && !acc_we) ? mem.mem_rdata : Result_in;
            wb_addr_d     = Addr_Write_Reg_in;
            wb_we_d       = Reg_Write_En_in;
            pc_redirect_d = (src != RS_NONE);
            if (src == RS_RET)
                pc_target_d = mem.mem_rdata;
            else if (src != RS_NONE)
                pc_target_d = {{(DATA_W-16){1'b0}}, imm_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_data_q     <= '0;
            wb_addr_q     <= '0;
            wb_we_q       <= 1'b0;
            pc_redirect_q <= 1'b0;
            pc_target_q   <= '0;
        end else begin
            wb_data_q     <= wb_data_d;
            wb_addr_q     <= wb_addr_d;
            wb_we_q       <= wb_we_d;
            pc_redirect_q <= pc_redirect_d;
            pc_target_q   <= pc_target_d;
        end
    end

    assign wb_data     = wb_data_q;
    assign wb_addr     = wb_addr_q;
    assign wb_we       = wb_we_q;
    assign pc_redirect = pc_redirect_q;
    assign pc_target   = pc_target_q;

endmodule

// File: tb/tb_stage4_mem_access.sv
// Scoreboard bench for stage4_mem_access: directed + random ops, memory responder, reference model.
module tb_stage4_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Result_in, data1_in;
    logic [15:0] imm_in;
    logic [7:0]  SP_Data_in;
    logic        Memory_Read_in, Memory_Write_in, Reg_Write_En_in, WB_Mux_sel_in;
    logic [4:0]  Addr_Write_Reg_in;
    logic        BR_Ex_in, JMP_flag_in, CALL_flag_in, RET_flag_in;
    logic        stall, wb_we, pc_redirect, mem_err;
    logic [31:0] wb_data, pc_target;
    logic [4:0]  wb_addr;

    logic        resp_ack = 1'b0, force_ack = 1'b0, resp_en = 1'b0;
    logic [31:0] resp_rdata = 32'h0;

    stage4_mem_access_if #(.ADDR_W(8), .DATA_W(32)) mem_bus ();
    assign mem_bus.mem_ack   = resp_ack | force_ack;
    assign mem_bus.mem_rdata = resp_rdata;

    stage4_mem_access dut (
        .clk(clk), .reset(reset), .Result_in(Result_in), .data1_in(data1_in),
        .imm_in(imm_in), .SP_Data_in(SP_Data_in), .Memory_Read_in(Memory_Read_in),
        .Memory_Write_in(Memory_Write_in), .Reg_Write_En_in(Reg_Write_En_in),
        .WB_Mux_sel_in(WB_Mux_sel_in), .Addr_Write_Reg_in(Addr_Write_Reg_in),
        .BR_Ex_in(BR_Ex_in), .JMP_flag_in(JMP_flag_in), .CALL_flag_in(CALL_flag_in),
        .RET_flag_in(RET_flag_in), .stall(stall), .mem(mem_bus), .wb_data(wb_data),
        .wb_addr(wb_addr), .wb_we(wb_we), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res, d1;
        logic [15:0] imm;
        logic [7:0]  sp;
        logic [4:0]  ra;
        bit rd, wr, rwe, sel, br, jmp, call, ret;
        int w;
    } op_t;
    typedef struct { bit we; bit redir; logic [31:0] data; logic [4:0] addr; logic [31:0] target; } exp_wb_t;
    typedef struct { bit we; logic [7:0] addr; logic [31:0] wdata; } exp_acc_t;

    exp_wb_t     exp_q[$];
    exp_acc_t    acc_q[$];
    int          wait_q[$];
    logic [31:0] ref_mem [256];
    logic [31:0] ram     [256];
    int          n_cmp = 0, n_err = 0;
    bit          run_dead = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic zero_op(output op_t op);
        op.res = '0; op.d1 = '0; op.imm = '0; op.sp = '0; op.ra = '0;
        op.rd = 0; op.wr = 0; op.rwe = 0; op.sel = 0; op.br = 0; op.jmp = 0;
        op.call = 0; op.ret = 0; op.w = 0;
    endtask

    task automatic drive(input op_t op);
        Result_in = op.res; data1_in = op.d1; imm_in = op.imm; SP_Data_in = op.sp;
        Memory_Read_in = op.rd; Memory_Write_in = op.wr; Reg_Write_En_in = op.rwe;
        WB_Mux_sel_in = op.sel; Addr_Write_Reg_in = op.ra; BR_Ex_in = op.br;
        JMP_flag_in = op.jmp; CALL_flag_in = op.call; RET_flag_in = op.ret;
    endtask

    task automatic clear_in();
        op_t z;
        zero_op(z);
        drive(z);
    endtask

    // Reference model: architectural effect of one op, then drive it and track stall/latency
    task automatic run_op(input op_t op);
        bit          acc, we, ok;
        logic [7:0]  a;
        logic [31:0] rv;
        exp_wb_t     e;
        int          n;
        if (run_dead) return;
        acc = op.rd | op.wr | op.call | op.ret;
        we  = op.wr | op.call;
        a   = (op.call | op.ret) ? op.sp : op.res[7:0];
        rv  = ref_mem[a];
        if (acc) begin
            wait_q.push_back(op.w);
            acc_q.push_back('{we, a, op.d1});
            if (we) ref_mem[a] = op.d1;
        end
        e.we     = op.rwe;
        e.addr   = op.ra;
        e.data   = (op.sel && acc && !we) ? rv : op.res;
        e.redir  = op.br | op.jmp | op.call | op.ret;
        e.target = op.ret ? rv : {16'h0, op.imm};
        if (e.we || e.redir) exp_q.push_back(e);
        drive(op);
        n = 0; ok = 0;
        repeat (64) begin
            @(negedge clk);
            if (!stall) begin ok = 1; break; end
            n++;
        end
        if (!ok) begin
            chk("stall_release_timeout", 32'(n), 32'(acc ? op.w + 1 : 0));
            run_dead = 1;
            return;
        end
        chk("stall_cycles", 32'(n), 32'(acc ? op.w + 1 : 0));
        @(posedge clk); #1;
        chk("wb_we_latency", 32'(wb_we), 32'(op.rwe));
        chk("redirect_latency", 32'(pc_redirect), 32'(e.redir));
    endtask

    task automatic rand_op(output op_t op);
        int kind;
        zero_op(op);
        op.res = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
        op.d1  = $urandom();
        op.imm = 16'($urandom());
        op.sp  = 8'($urandom_range(240, 255));
        op.ra  = 5'($urandom());
        op.rwe = ($urandom_range(0, 3) != 0);
        op.sel = 1'($urandom_range(0, 1));
        op.w   = $urandom_range(0, 3);
        op.br  = ($urandom_range(0, 5) == 0);
        kind   = $urandom_range(0, 7);
        case (kind)
            2: op.rd = 1;
            3: op.wr = 1;
            4: begin op.rd = 1; op.wr = 1; end
            5: op.call = 1;
            6: op.ret = 1;
            7: op.jmp = 1;
            default: ;
        endcase
    endtask

    // Memory responder: checks the launched access, acks after the scheduled wait
    initial begin
        exp_acc_t ea;
        int       w;
        forever begin
            @(posedge clk); #1;
            if (resp_en && mem_bus.mem_req) begin
                w = 0;
                if (wait_q.size() == 0 || acc_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_mem_req at %0t", $time);
                end else begin
                    w  = wait_q.pop_front();
                    ea = acc_q.pop_front();
                    chk("mem_we", 32'(mem_bus.mem_we), 32'(ea.we));
                    chk("mem_addr", 32'(mem_bus.mem_addr), 32'(ea.addr));
                    if (ea.we) chk("mem_wdata", mem_bus.mem_wdata, ea.wdata);
                end
                repeat (w) begin @(posedge clk); #1; end
                resp_ack   = 1'b1;
                resp_rdata = ram[mem_bus.mem_addr];
                if (mem_bus.mem_we) ram[mem_bus.mem_addr] = mem_bus.mem_wdata;
                @(posedge clk); #1;
                resp_ack   = 1'b0;
                resp_rdata = $urandom();
            end
        end
    end

    // Monitor: every writeback or redirect pulse consumes one expected record
    initial begin
        exp_wb_t e;
        forever begin
            @(negedge clk);
            if (!reset && (wb_we || pc_redirect)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_wb: wb_we=%0b pc_redirect=%0b at %0t", wb_we, pc_redirect, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_we", 32'(wb_we), 32'(e.we));
                    chk("pc_redirect", 32'(pc_redirect), 32'(e.redir));
                    if (e.we) begin
                        chk("wb_data", wb_data, e.data);
                        chk("wb_addr", 32'(wb_addr), 32'(e.addr));
                    end
                    if (e.redir) chk("pc_target", pc_target, e.target);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        op_t op;
        logic [31:0] v;
        int n;
        for (int i = 0; i < 256; i++) begin
            v = $urandom();
            ref_mem[i] = v;
            ram[i]     = v;
        end
        clear_in();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_wb_we", 32'(wb_we), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_addr", 32'(wb_addr), 0);
        chk("rst_pc_redirect", 32'(pc_redirect), 0);
        chk("rst_pc_target", pc_target, 0);
        chk("rst_mem_err", 32'(mem_err), 0);
        chk("rst_mem_req", 32'(mem_bus.mem_req), 0);
        chk("rst_stall", 32'(stall), 0);
        resp_en = 1'b1;

        zero_op(op); op.res = 32'd18; op.rwe = 1; op.ra = 5'd3;
        run_op(op);
        zero_op(op); op.wr = 1; op.res = 32'h10; op.d1 = 32'hABC; op.w = 2;
        run_op(op);
        zero_op(op); op.rd = 1; op.res = 32'h10; op.sel = 1; op.rwe = 1; op.ra = 5'd7; op.w = 1;
        run_op(op);
        zero_op(op); op.call = 1; op.sp = 8'hFE; op.d1 = 32'h40; op.imm = 16'h20; op.w = 1;
        run_op(op);
        zero_op(op); op.ret = 1; op.sp = 8'hFE; op.imm = 16'h1234; op.w = 0;
        run_op(op);
        zero_op(op); op.rd = 1; op.res = 32'h5; op.sel = 1; op.rwe = 1; op.ra = 5'd9; op.w = 0;
        run_op(op);
        clear_in();

        // Reset in the middle of an access; a stray ack afterwards must be ignored
        if (!run_dead) begin
            @(posedge clk); #1;
            resp_en = 1'b0;
            zero_op(op); op.wr = 1; op.res = 32'h22; op.d1 = 32'hDEAD; op.rwe = 1; op.ra = 5'd4;
            drive(op);
            @(posedge clk); #1;
            chk("midacc_mem_req", 32'(mem_bus.mem_req), 1);
            reset = 1'b1;
            clear_in();
            @(posedge clk); #1;
            reset = 1'b0;
            chk("midrst_mem_req", 32'(mem_bus.mem_req), 0);
            chk("midrst_wb_we", 32'(wb_we), 0);
            chk("midrst_stall", 32'(stall), 0);
            force_ack = 1'b1;
            @(posedge clk); #1;
            force_ack = 1'b0;
            chk("stray_ack_mem_req", 32'(mem_bus.mem_req), 0);
            chk("stray_ack_wb_we", 32'(wb_we), 0);
            chk("stray_ack_redirect", 32'(pc_redirect), 0);
            chk("stray_ack_stall", 32'(stall), 0);
            resp_en = 1'b1;
        end

`ifdef MEM_TIMEOUT_EN
        if (!run_dead) begin
            resp_en = 1'b0;
            zero_op(op); op.rd = 1; op.res = 32'h3; op.sel = 1; op.rwe = 1; op.ra = 5'd2;
            drive(op);
            n = 0;
            repeat (40) begin
                @(negedge clk);
                if (!stall) break;
                n++;
            end
            chk("timeout_stall_cycles", 32'(n), 32'd16);
            @(posedge clk); #1;
            chk("timeout_mem_err", 32'(mem_err), 1);
            chk("timeout_wb_we", 32'(wb_we), 0);
            chk("timeout_mem_req", 32'(mem_bus.mem_req), 0);
            clear_in();
            resp_en = 1'b1;
        end
`endif

        for (int i = 0; i < 200; i++) begin
            rand_op(op);
            run_op(op);
        end

        clear_in();
        n = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("exp_q_drained", 32'(exp_q.size()), 0);
        chk("acc_q_drained", 32'(acc_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
